// File: rtl/sdc_write_block_seq.sv
// SD-card single-block write sequencer for DAT0 in 1-bit mode: Nwr, start bit, data, CRC16, end bit, token, busy.
// Optional busy timeout is compiled in with `define SDC_WR_TIMEOUT_EN.
module sdc_write_block_seq #(
  parameter int          BLOCK_BYTES   = 512,
  parameter int          NWR_BITS      = 2,
  parameter int          RESP_WAIT_MAX = 8,
  parameter logic [15:0] BUSY_MAX      = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_req,
  input  logic       dat0_in,
  output logic       dat0_out,
  output logic       dat0_oe,
  output logic       sd_clk_en,
  output logic       busy,
  output logic       done,
  output logic [2:0] status,
  output logic       error
);

  localparam int CNT_W = $clog2(8 * BLOCK_BYTES + 17);
  localparam logic [CNT_W-1:0] DATA_LAST      = CNT_W'(8 * BLOCK_BYTES - 1);
  localparam logic [CNT_W-1:0] BLOCK_LEN      = CNT_W'(BLOCK_BYTES);
  localparam logic [CNT_W-1:0] NWR_LAST       = CNT_W'(NWR_BITS - 1);
  localparam logic [CNT_W-1:0] RESP_WAIT_LAST = CNT_W'(RESP_WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CRC_LAST       = CNT_W'(15);
  localparam logic [CNT_W-1:0] RESP_LAST      = CNT_W'(3);

  if (BLOCK_BYTES < 1 || BLOCK_BYTES > 4095 || NWR_BITS < 1 || RESP_WAIT_MAX < 1 ||
      BUSY_MAX == 16'd0) begin : g_bad_param
    $error("sdc_write_block_seq: parameter out of range");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_START, S_DATA, S_CRC, S_END, S_RESP_WAIT, S_RESP, S_BUSY, S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [15:0]      crc_q, crc_d;
  logic [2:0]       status_q, status_d;
  logic             error_q, error_d;
  logic [15:0]      crc_next;
  logic             prefetch;
`ifdef SDC_WR_TIMEOUT_EN
  logic [15:0]      busy_cnt_q, busy_cnt_d;
`endif

  assign crc_next = {crc_q[14:0], 1'b0} ^ ({16{crc_q[15] ^ shift_q[7]}} & 16'h1021);
  assign prefetch = (state_q == S_PRE) || (state_q == S_START) || (state_q == S_DATA);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    taken_d      = taken_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    crc_d        = crc_q;
    status_d     = status_q;
    error_d      = error_q;
`ifdef SDC_WR_TIMEOUT_EN
    busy_cnt_d   = busy_cnt_q;
`endif
    sd_clk_en    = 1'b1;
    dat0_out     = 1'b1;
    dat0_oe      = 1'b0;
    // Byte 0 is requested in the same cycle start is accepted.
    if (state_q == S_IDLE) byte_req = start;
    else byte_req = prefetch && !hold_valid_q && (taken_q != BLOCK_LEN);

    case (state_q)
      S_IDLE: begin
        sd_clk_en = 1'b0;
        if (start) begin
          state_d  = S_PRE;
          cnt_d    = '0;
          crc_d    = 16'h0000;
          status_d = 3'b000;
          error_d  = 1'b0;
        end
      end
      S_PRE: begin
        dat0_oe = 1'b1;
        if (cnt_q == NWR_LAST) begin
          state_d = S_START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        dat0_oe  = 1'b1;
        dat0_out = 1'b0;
        if (!hold_valid_q) begin
          sd_clk_en = 1'b0;
        end else begin
          state_d      = S_DATA;
          cnt_d        = '0;
          shift_d      = hold_q;
          hold_valid_d = 1'b0;
        end
      end
      S_DATA: begin
        dat0_oe  = 1'b1;
        dat0_out = shift_q[7];
        // Stall the card clock on the last bit of a byte until the next byte is held.
        if (cnt_q[2:0] == 3'd7 && cnt_q != DATA_LAST && !hold_valid_q) begin
          sd_clk_en = 1'b0;
        end else begin
          crc_d = crc_next;
          if (cnt_q == DATA_LAST) begin
            state_d = S_CRC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q[2:0] == 3'd7) begin
              shift_d      = hold_q;
              hold_valid_d = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
        end
      end
      S_CRC: begin
        dat0_oe  = 1'b1;
        dat0_out = crc_q[15];
        crc_d    = {crc_q[14:0], 1'b0};
        if (cnt_q == CRC_LAST) begin
          state_d = S_END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_END: begin
        dat0_oe = 1'b1;
        state_d = S_RESP_WAIT;
        cnt_d   = '0;
      end
      S_RESP_WAIT: begin
        if (!dat0_in) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else if (cnt_q == RESP_WAIT_LAST) begin
          state_d  = S_FINISH;
          status_d = 3'b111;
          error_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (cnt_q == RESP_LAST) begin
          state_d = S_BUSY;
          cnt_d   = '0;
`ifdef SDC_WR_TIMEOUT_EN
          busy_cnt_d = 16'd0;
`endif
        end else begin
          status_d = {status_q[1:0], dat0_in};
          cnt_d    = cnt_q + 1'b1;
        end
      end
      S_BUSY: begin
        if (dat0_in) begin
          state_d = S_FINISH;
          error_d = (status_q != 3'b010);
`ifdef SDC_WR_TIMEOUT_EN
        end else if (busy_cnt_q == BUSY_MAX - 16'd1) begin
          state_d = S_FINISH;
          error_d = 1'b1;
        end else begin
          busy_cnt_d = busy_cnt_q + 16'd1;
`endif
        end
      end
      S_FINISH: begin
        state_d      = S_IDLE;
        cnt_d        = '0;
        taken_d      = '0;
        hold_valid_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (byte_req && byte_valid) begin
      hold_d       = byte_in;
      hold_valid_d = 1'b1;
      taken_d      = taken_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      taken_q      <= '0;
      shift_q      <= 8'h00;
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
      crc_q        <= 16'h0000;
      status_q     <= 3'b000;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      taken_q      <= taken_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      crc_q        <= crc_d;
      status_q     <= status_d;
      error_q      <= error_d;
    end
  end

`ifdef SDC_WR_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_cnt_q <= 16'd0;
    else          busy_cnt_q <= busy_cnt_d;
  end
`endif

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_FINISH);
  assign status = status_q;
  assign error  = error_q;

endmodule

// File: tb/tb_sdc_write_block_seq.sv
// Directed bench for sdc_write_block_seq: vector table of whole-block writes plus reset corner case.
// Build with SDC_WR_TIMEOUT_EN defined to add the busy-timeout vector.
module tb_sdc_write_block_seq;

  localparam int BB    = 512;
  localparam int NWR   = 2;
  localparam int RWM   = 8;
  localparam int BMAX  = 16;
  localparam int NBITS = 8 * BB + 18;
  localparam int LIMIT = NBITS + 400;
`ifdef SDC_WR_TIMEOUT_EN
  localparam int NV = 6;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int NV = 5;
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       dat0_in = 1'b1;
  logic       byte_req, dat0_out, dat0_oe, sd_clk_en, busy, done, error;
  logic [2:0] status;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdc_write_block_seq #(
    .BLOCK_BYTES(BB), .NWR_BITS(NWR), .RESP_WAIT_MAX(RWM), .BUSY_MAX(16'(BMAX))
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_req(byte_req), .dat0_in(dat0_in),
    .dat0_out(dat0_out), .dat0_oe(dat0_oe), .sd_clk_en(sd_clk_en), .busy(busy),
    .done(done), .status(status), .error(error)
  );

  typedef struct {
    int         pat;         // 0: all 0xFF, 1: byte index modulo 256
    int         stall_byte;  // withhold this byte until 3 stall cycles seen (-1: never)
    int         restart_cyc; // cycle of a stray start pulse mid-transfer (-1: never)
    bit         give_tok;
    logic [2:0] tok;
    int         tok_dly;
    int         busy_cyc;
    logic [2:0] exp_status;
    logic       exp_error;
    int         exp_stalls;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat_byte(input int pat, input int i);
    return (pat == 0) ? 8'hFF : 8'(i);
  endfunction

  function automatic logic [15:0] crc_model(input int pat);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'h0000;
    for (int i = 0; i < BB; i++) begin
      b = pat_byte(pat, i);
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ b[k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic run_block(input vec_t v, input int vi);
    logic        stream [NBITS];
    int          nb, cyc, first0, endcyc, stalls, r, done_r, bidx, j, nbad, exp_done_r, bcyc;
    bit          xfer, finished, stall_done;
    logic [2:0]  st;
    logic        er;
    logic [7:0]  b;
    logic [15:0] crc_got;
    nb = 0; cyc = 0; first0 = -1; endcyc = -1; stalls = 0; r = -1; done_r = -1; bidx = 0;
    finished = 1'b0; stall_done = 1'b0; st = 3'b000; er = 1'b0;
    @(negedge clk);
    start = 1'b1; byte_valid = 1'b1; byte_in = pat_byte(v.pat, 0); dat0_in = 1'b1;
    #1 xfer = byte_req & byte_valid;
    while (!finished && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      start = (cyc == v.restart_cyc);
      if (xfer) bidx++;
      if (busy && !sd_clk_en) stalls++;
      if (nb < NBITS) begin
        if (first0 < 0 && dat0_oe && !dat0_out) first0 = cyc;
        if (first0 >= 0 && dat0_oe && sd_clk_en) begin
          stream[nb] = dat0_out;
          if (nb == NBITS - 1) endcyc = cyc;
          nb++;
        end
        if (done) finished = 1'b1;
      end else begin
        r++;
        if (r == 0) chk($sformatf("v%0d oe_release", vi), 32'(dat0_oe), 32'd0);
        if (done) begin
          finished = 1'b1; done_r = r; st = status; er = error;
        end
      end
      if (v.stall_byte >= 0 && bidx == v.stall_byte && !stall_done) begin
        if (stalls >= 3) begin byte_valid = 1'b1; stall_done = 1'b1; end
        else byte_valid = 1'b0;
      end
      byte_in = pat_byte(v.pat, bidx);
      dat0_in = 1'b1;
      if (r >= 0 && v.give_tok) begin
        j = r - v.tok_dly;
        if (j == 0) dat0_in = 1'b0;
        else if (j >= 1 && j <= 3) dat0_in = v.tok[3 - j];
        else if (j >= 5 && j < 5 + v.busy_cyc) dat0_in = 1'b0;
      end
      #1 xfer = byte_req & byte_valid;
    end
    byte_valid = 1'b0; dat0_in = 1'b1; start = 1'b0;
    chk($sformatf("v%0d done_seen", vi), 32'(done_r >= 0), 32'd1);
    chk($sformatf("v%0d latency", vi), 32'(first0), 32'(NWR + 1));
    chk($sformatf("v%0d bit_count", vi), 32'(nb), 32'(NBITS));
    if (nb == NBITS) begin
      nbad = 0;
      for (int i = 0; i < 8 * BB; i++) begin
        b = pat_byte(v.pat, i / 8);
        if (stream[i + 1] !== b[7 - (i % 8)]) nbad++;
      end
      chk($sformatf("v%0d start_bit", vi), 32'(stream[0]), 32'd0);
      chk($sformatf("v%0d data_bit_errors", vi), 32'(nbad), 32'd0);
      crc_got = 16'h0000;
      for (int k = 0; k < 16; k++) crc_got = {crc_got[14:0], stream[8 * BB + 1 + k]};
      chk($sformatf("v%0d crc", vi), 32'(crc_got), 32'(crc_model(v.pat)));
      if (v.pat == 0) chk($sformatf("v%0d crc_ff", vi), 32'(crc_got), 32'h7FA1);
      chk($sformatf("v%0d end_bit", vi), 32'(stream[NBITS - 1]), 32'd1);
    end
    chk($sformatf("v%0d end_cycle", vi), 32'(endcyc), 32'(NWR + 1 + 8 * BB + 17 + v.exp_stalls));
    chk($sformatf("v%0d stalls", vi), 32'(stalls), 32'(v.exp_stalls));
    if (!v.give_tok) exp_done_r = RWM;
    else begin
      bcyc = v.busy_cyc;
      if (TMO_EN && bcyc > BMAX) bcyc = BMAX;
      exp_done_r = v.tok_dly + 6 + bcyc;
    end
    chk($sformatf("v%0d done_cycle", vi), 32'(done_r), 32'(exp_done_r));
    chk($sformatf("v%0d status", vi), 32'(st), 32'(v.exp_status));
    chk($sformatf("v%0d error", vi), 32'(er), 32'(v.exp_error));
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", vi), 32'(done), 32'd0);
    chk($sformatf("v%0d busy_clear", vi), 32'(busy), 32'd0);
    chk($sformatf("v%0d status_hold", vi), 32'({error, status}), 32'({v.exp_error, v.exp_status}));
    $display("vec %0d: pat=%0d status=%b error=%b stalls=%0d done_r=%0d", vi, v.pat, st, er, stalls, done_r);
  endtask

  initial begin
    vecs[0] = '{0, -1, -1, 1'b1, 3'b010, 2, 5, 3'b010, 1'b0, 0};
    vecs[1] = '{1, 100, -1, 1'b1, 3'b010, 1, 3, 3'b010, 1'b0, 3};
    vecs[2] = '{1, -1, -1, 1'b1, 3'b101, 0, 2, 3'b101, 1'b1, 0};
    vecs[3] = '{0, -1, -1, 1'b0, 3'b000, 0, 0, 3'b111, 1'b1, 0};
    vecs[4] = '{1, -1, 500, 1'b1, 3'b010, RWM - 1, 0, 3'b010, 1'b0, 0};
`ifdef SDC_WR_TIMEOUT_EN
    vecs[5] = '{0, -1, -1, 1'b1, 3'b010, 1, 40, 3'b010, 1'b1, 0};
`endif

    repeat (3) @(negedge clk);
    chk("rst dat0_out", 32'(dat0_out), 32'd1);
    chk("rst dat0_oe", 32'(dat0_oe), 32'd0);
    chk("rst sd_clk_en", 32'(sd_clk_en), 32'd0);
    chk("rst byte_req", 32'(byte_req), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst status", 32'(status), 32'd0);
    chk("rst error", 32'(error), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) run_block(vecs[i], i);

    // Reset pulsed in the middle of the data phase, then a clean block.
    @(negedge clk);
    start = 1'b1; byte_valid = 1'b1; byte_in = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    chk("mid oe_before_reset", 32'(dat0_oe), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid rst dat0_oe", 32'(dat0_oe), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst sd_clk_en", 32'(sd_clk_en), 32'd0);
    chk("mid rst byte_req", 32'(byte_req), 32'd0);
    @(negedge clk);
    reset_n = 1'b1; byte_valid = 1'b0;
    run_block(vecs[0], 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
